// File: rtl/hazard_unit_pkg.sv
// Shared pipeline constants and types for the hazard / forwarding unit.
// Latency: n/a (types, constants and one pure helper function).
// Backpressure: n/a.
package hazard_unit_pkg;

   // Register-file address width (32 architectural registers).
   localparam int REG_AW = 5;

   // Stall counter width.
   localparam int CNT_W = 16;

   typedef logic [REG_AW-1:0] reg_addr_t;

   // ALU operand source select.
   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_e;

   // Load-use FSM states.
   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_STALL1 = 1'b1
   } hz_state_e;

   // Shadow of the EX/MEM pipeline register fields the unit cares about.
   typedef struct packed {
      reg_addr_t dst;
      logic      regwrite;
      logic      memread;
   } mem_stage_t;

   // Shadow of the MEM/WB pipeline register fields the unit cares about.
   typedef struct packed {
      reg_addr_t dst;
      logic      regwrite;
   } wb_stage_t;

   // True when a writing stage produces the register being read.
   // $0 is hard-wired to zero, so it never matches.
   function automatic logic stage_hit(input reg_addr_t src,
                                      input reg_addr_t dst,
                                      input logic      regwrite);
      return regwrite && (dst != '0) && (dst == src);
   endfunction

endpackage

// File: rtl/fwd_select.sv
// Forwarding select for one ALU operand: picks MEM, WB or register file.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs every cycle.
module fwd_select
   import hazard_unit_pkg::*;
(
   input  logic [REG_AW-1:0] src_addr,
   input  mem_stage_t        mem_stage,
   input  wb_stage_t         wb_stage,
   output logic [1:0]        sel
);

   logic mem_hit;
   logic wb_hit;

   assign mem_hit = stage_hit(src_addr, mem_stage.dst, mem_stage.regwrite);
   assign wb_hit  = stage_hit(src_addr, wb_stage.dst,  wb_stage.regwrite);

   // MEM holds the younger result, so it wins over WB.
   always_comb begin
      sel = FWD_RF;
      if (mem_hit) begin
         sel = FWD_MEM;
      end else if (wb_hit) begin
         sel = FWD_WB;
      end
   end

endmodule

// File: rtl/hazard_unit.sv
// Load-use stall, branch squash and ALU forwarding control for a 5-stage pipe.
// Latency: all control outputs combinational (zero cycles); shadows/counter 1 cycle.
// Backpressure: none; a load-use hazard stalls PC/IF-ID for exactly one cycle.
module hazard_unit
   import hazard_unit_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   // decode stage
   input  logic [REG_AW-1:0] IDRSAddr_i,
   input  logic [REG_AW-1:0] IDRTAddr_i,
   input  logic              Branch_i,
   // execute stage (ID/EX register outputs)
   input  logic [REG_AW-1:0] EXRSAddr_i,
   input  logic [REG_AW-1:0] EXRTAddr_i,
   input  logic [REG_AW-1:0] EXDstAddr_i,
   input  logic              EXRegWrite_i,
   input  logic              EXMemRead_i,
   // control outputs
   output logic              Stall_o,
   output logic              IDEXFlush_o,
   output logic              IFIDFlush_o,
   output logic [1:0]        ForwardA_o,
   output logic [1:0]        ForwardB_o,
   output logic [CNT_W-1:0]  StallCnt_o
);

   mem_stage_t       mem_q;
   wb_stage_t        wb_q;
   hz_state_e        state_q;
   hz_state_e        state_d;
   logic [CNT_W-1:0] stall_cnt_q;
   logic             raw_hazard;
   logic             load_use;
   logic [1:0]       fwd_a;
   logic [1:0]       fwd_b;

   // The MEM load flag is tracked so the shadow mirrors the real EX/MEM
   // register, but no current decision depends on it.
   logic unused_mem_memread;
   assign unused_mem_memread = mem_q.memread;

   // Shadow pipeline: EX fields move into MEM, MEM moves into WB.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         mem_q <= '0;
         wb_q  <= '0;
      end else begin
         mem_q.dst      <= EXDstAddr_i;
         mem_q.regwrite <= EXRegWrite_i;
         mem_q.memread  <= EXMemRead_i;
         wb_q.dst       <= mem_q.dst;
         wb_q.regwrite  <= mem_q.regwrite;
      end
   end

   // A load in EX whose destination is read by the instruction in ID.
   assign raw_hazard = EXMemRead_i
                    && (EXDstAddr_i != '0)
                    && ((EXDstAddr_i == IDRSAddr_i) || (EXDstAddr_i == IDRTAddr_i));

   // Load-use FSM state register.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and stall decision; STALL1 holds the inserted bubble in EX,
   // which cannot create a hazard, so no stall is raised there.
   always_comb begin
      state_d  = state_q;
      load_use = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (raw_hazard) begin
               load_use = 1'b1;
               state_d  = ST_STALL1;
            end
         end
         ST_STALL1: begin
            state_d = ST_RUN;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   assign Stall_o     = load_use;
   assign IDEXFlush_o = load_use;
   // A stall keeps the branch in ID, so it is re-evaluated next cycle.
   assign IFIDFlush_o = Branch_i && !load_use;

   // Saturating count of stall cycles.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         stall_cnt_q <= '0;
      end else if (load_use && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign StallCnt_o = stall_cnt_q;

   fwd_select u_fwd_a (
      .src_addr  (EXRSAddr_i),
      .mem_stage (mem_q),
      .wb_stage  (wb_q),
      .sel       (fwd_a)
   );

   fwd_select u_fwd_b (
      .src_addr  (EXRTAddr_i),
      .mem_stage (mem_q),
      .wb_stage  (wb_q),
      .sel       (fwd_b)
   );

   // Shadows are not yet trustworthy while reset is asserted.
   assign ForwardA_o = rst_i ? fwd_a : FWD_RF;
   assign ForwardB_o = rst_i ? fwd_b : FWD_RF;

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;
   import hazard_unit_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [4:0]  IDRSAddr_i, IDRTAddr_i;
   logic        Branch_i;
   logic [4:0]  EXRSAddr_i, EXRTAddr_i, EXDstAddr_i;
   logic        EXRegWrite_i, EXMemRead_i;
   logic        Stall_o, IDEXFlush_o, IFIDFlush_o;
   logic [1:0]  ForwardA_o, ForwardB_o;
   logic [15:0] StallCnt_o;

   always #5 clk_i = ~clk_i;

   hazard_unit dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .IDRSAddr_i   (IDRSAddr_i),
      .IDRTAddr_i   (IDRTAddr_i),
      .Branch_i     (Branch_i),
      .EXRSAddr_i   (EXRSAddr_i),
      .EXRTAddr_i   (EXRTAddr_i),
      .EXDstAddr_i  (EXDstAddr_i),
      .EXRegWrite_i (EXRegWrite_i),
      .EXMemRead_i  (EXMemRead_i),
      .Stall_o      (Stall_o),
      .IDEXFlush_o  (IDEXFlush_o),
      .IFIDFlush_o  (IFIDFlush_o),
      .ForwardA_o   (ForwardA_o),
      .ForwardB_o   (ForwardB_o),
      .StallCnt_o   (StallCnt_o)
   );

   typedef struct packed {
      logic [4:0] rs, rt;
      logic       br;
      logic [4:0] exrs, exrt, exdst;
      logic       exrw, exmr;
   } in_t;

   typedef struct packed {
      logic       stall, idex, ifid;
      logic [1:0] fa, fb;
      logic [15:0] cnt;
   } exp_t;

   typedef struct {
      string name;
      in_t   in;
      exp_t  exp;
   } vec_t;

   int    n_vec = 0;
   int    n_err = 0;
   exp_t  exp_q[$];
   string name_q[$];

   function automatic vec_t mk(string n,
                               logic [4:0] rs, logic [4:0] rt, logic br,
                               logic [4:0] exrs, logic [4:0] exrt, logic [4:0] exdst,
                               logic exrw, logic exmr,
                               logic st, logic id, logic ifl,
                               logic [1:0] fa, logic [1:0] fb, logic [15:0] cnt);
      vec_t v;
      v.name = n;
      v.in   = '{rs: rs, rt: rt, br: br, exrs: exrs, exrt: exrt, exdst: exdst,
                 exrw: exrw, exmr: exmr};
      v.exp  = '{stall: st, idex: id, ifid: ifl, fa: fa, fb: fb, cnt: cnt};
      return v;
   endfunction

   task automatic drive(input in_t v);
      IDRSAddr_i   = v.rs;
      IDRTAddr_i   = v.rt;
      Branch_i     = v.br;
      EXRSAddr_i   = v.exrs;
      EXRTAddr_i   = v.exrt;
      EXDstAddr_i  = v.exdst;
      EXRegWrite_i = v.exrw;
      EXMemRead_i  = v.exmr;
   endtask

   task automatic chk(input string nm, input string fld,
                      input logic [15:0] act, input logic [15:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s.%s: got %h expected %h", nm, fld, act, req);
      end
   endtask

   task automatic check_out();
      exp_t  e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      chk(nm, "Stall_o",     {15'b0, Stall_o},     {15'b0, e.stall});
      chk(nm, "IDEXFlush_o", {15'b0, IDEXFlush_o}, {15'b0, e.idex});
      chk(nm, "IFIDFlush_o", {15'b0, IFIDFlush_o}, {15'b0, e.ifid});
      chk(nm, "ForwardA_o",  {14'b0, ForwardA_o},  {14'b0, e.fa});
      chk(nm, "ForwardB_o",  {14'b0, ForwardB_o},  {14'b0, e.fb});
      chk(nm, "StallCnt_o",  StallCnt_o,           e.cnt);
   endtask

   // Drive one cycle of stimulus just after the edge, sample on the falling edge.
   task automatic apply(input string nm, input logic rst, input in_t v, input exp_t e);
      @(posedge clk_i);
      #1;
      rst_i = rst;
      drive(v);
      exp_q.push_back(e);
      name_q.push_back(nm);
      @(negedge clk_i);
      check_out();
   endtask

   vec_t  tbl[18];
   in_t   idle;
   in_t   haz;
   exp_t  e;
   logic [15:0] exp_cnt;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      idle = '0;
      haz  = '{rs: 5'd7, rt: 5'd1, br: 1'b0, exrs: 5'd0, exrt: 5'd0, exdst: 5'd7,
               exrw: 1'b1, exmr: 1'b1};

      //            name            rs  rt br exrs exrt exdst rw mr  st id if fa     fb     cnt
      tbl[0]  = mk("idle",           0,  0, 0,  0,   0,   0,  0, 0, 0, 0, 0, 2'b00, 2'b00, 16'd0);
      tbl[1]  = mk("add3_in_ex",     0,  0, 0,  1,   2,   3,  1, 0, 0, 0, 0, 2'b00, 2'b00, 16'd0);
      tbl[2]  = mk("fwdA_mem",       0,  0, 0,  3,   4,   0,  0, 0, 0, 0, 0, 2'b10, 2'b00, 16'd0);
      tbl[3]  = mk("fwdA_wb",        0,  0, 0,  3,   0,   0,  0, 0, 0, 0, 0, 2'b01, 2'b00, 16'd0);
      tbl[4]  = mk("wr5_first",      0,  0, 0,  0,   0,   5,  1, 0, 0, 0, 0, 2'b00, 2'b00, 16'd0);
      tbl[5]  = mk("wr5_second",     0,  0, 0,  0,   5,   5,  1, 0, 0, 0, 0, 2'b00, 2'b10, 16'd0);
      tbl[6]  = mk("fwdB_mem_prio",  0,  0, 0,  5,   5,   0,  0, 0, 0, 0, 0, 2'b10, 2'b10, 16'd0);
      tbl[7]  = mk("fwdB_wb",        0,  0, 0,  0,   5,   0,  0, 0, 0, 0, 0, 2'b00, 2'b01, 16'd0);
      tbl[8]  = mk("add0_rw",        0,  0, 0,  0,   0,   0,  1, 0, 0, 0, 0, 2'b00, 2'b00, 16'd0);
      tbl[9]  = mk("lw0_no_stall",   0,  0, 0,  0,   0,   0,  1, 1, 0, 0, 0, 2'b00, 2'b00, 16'd0);
      tbl[10] = mk("r0_no_fwd",      0,  0, 0,  0,   0,   0,  0, 0, 0, 0, 0, 2'b00, 2'b00, 16'd0);
      tbl[11] = mk("lw7_hazard",     7,  1, 0,  0,   0,   7,  1, 1, 1, 1, 0, 2'b00, 2'b00, 16'd0);
      tbl[12] = mk("stall1_no_stall",7,  1, 0,  0,   0,   7,  1, 1, 0, 0, 0, 2'b00, 2'b00, 16'd1);
      tbl[13] = mk("run_again",      0,  0, 0,  0,   0,   0,  0, 0, 0, 0, 0, 2'b00, 2'b00, 16'd1);
      tbl[14] = mk("br_with_stall",  0,  9, 1,  0,   0,   9,  1, 1, 1, 1, 0, 2'b00, 2'b00, 16'd1);
      tbl[15] = mk("br_retry",       0,  0, 1,  0,   0,   0,  0, 0, 0, 0, 1, 2'b00, 2'b00, 16'd2);
      tbl[16] = mk("br_run_fwd_wb",  0,  0, 1,  9,   0,   0,  0, 0, 0, 0, 1, 2'b01, 2'b00, 16'd2);
      tbl[17] = mk("idle_end",       0,  0, 0,  0,   0,   0,  0, 0, 0, 0, 0, 2'b00, 2'b00, 16'd2);

      // Reset: outputs quiet, counter cleared.
      rst_i = 1'b0;
      drive(idle);
      repeat (2) @(posedge clk_i);
      apply("reset_hold", 1'b0, idle, '0);
      rst_i = 1'b1;

      for (int i = 0; i < 18; i++) begin
         apply(tbl[i].name, 1'b1, tbl[i].in, tbl[i].exp);
      end

      // Counter saturation: preload near the top, then stall repeatedly.
      force dut.stall_cnt_q = 16'hFFFC;
      #1;
      release dut.stall_cnt_q;
      exp_cnt = 16'hFFFC;
      for (int k = 0; k < 4; k++) begin
         e = '{stall: 1'b1, idex: 1'b1, ifid: 1'b0, fa: 2'b00, fb: 2'b00, cnt: exp_cnt};
         apply("sat_stall", 1'b1, haz, e);
         exp_cnt = (exp_cnt == 16'hFFFF) ? 16'hFFFF : exp_cnt + 16'd1;
         e = '{stall: 1'b0, idex: 1'b0, ifid: 1'b0, fa: 2'b00, fb: 2'b00, cnt: exp_cnt};
         apply("sat_gap", 1'b1, idle, e);
      end

      // Reset while in STALL1: MEM holds $7, EX rs = $7.
      e = '{stall: 1'b1, idex: 1'b1, ifid: 1'b0, fa: 2'b00, fb: 2'b00, cnt: 16'hFFFF};
      apply("rst_pre_hazard", 1'b1, haz, e);
      e = '{stall: 1'b0, idex: 1'b0, ifid: 1'b0, fa: 2'b00, fb: 2'b00, cnt: 16'hFFFF};
      apply("rst_in_stall1", 1'b0, '{rs: 5'd0, rt: 5'd0, br: 1'b0, exrs: 5'd7, exrt: 5'd7,
                                      exdst: 5'd0, exrw: 1'b0, exmr: 1'b0}, e);
      e = '{stall: 1'b0, idex: 1'b0, ifid: 1'b0, fa: 2'b00, fb: 2'b00, cnt: 16'h0000};
      apply("rst_after", 1'b1, '{rs: 5'd0, rt: 5'd0, br: 1'b0, exrs: 5'd7, exrt: 5'd7,
                                  exdst: 5'd0, exrw: 1'b0, exmr: 1'b0}, e);
      e = '{stall: 1'b1, idex: 1'b1, ifid: 1'b0, fa: 2'b00, fb: 2'b00, cnt: 16'h0000};
      apply("post_rst_hazard", 1'b1, haz, e);
      e = '{stall: 1'b0, idex: 1'b0, ifid: 1'b0, fa: 2'b00, fb: 2'b00, cnt: 16'h0001};
      apply("post_rst_count", 1'b1, idle, e);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
